// File: rtl/seg7_pkg.sv
// Constants and types shared by the 7-segment register writer and the 7-segment peripheral.
package seg7_pkg;
  localparam int         NUM_DIGITS   = 6;
  localparam int         DIGIT_STRIDE = 4;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam int         DIGIT_BITS   = 4;
  localparam int         IDX_W        = $clog2(NUM_DIGITS);

  typedef logic [DIGIT_BITS-1:0] digit_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP,
    ST_DONE
  } wr_state_e;
endpackage

// File: rtl/seg7_axil_wr_beat.sv
// Single AXI4-Lite write beat: AW/W pending flags set by start_i, each cleared on its own handshake.
// BREADY follows resp_en_i; the response handshake and its error status are reported combinationally.
module seg7_axil_wr_beat
  import seg7_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       issue_en_i,
  input  logic       resp_en_i,
  input  logic       awready_i,
  input  logic       wready_i,
  input  logic       bvalid_i,
  input  logic [1:0] bresp_i,
  output logic       awvalid_o,
  output logic       wvalid_o,
  output logic       bready_o,
  output logic       issue_done_o,
  output logic       b_hs_o,
  output logic       b_err_o
);

  logic aw_pend_q, aw_pend_d;
  logic w_pend_q, w_pend_d;

  // Flags may be left set after a skipped digit; issue_en_i keeps them off the bus.
  assign awvalid_o    = aw_pend_q & issue_en_i;
  assign wvalid_o     = w_pend_q & issue_en_i;
  assign bready_o     = resp_en_i;
  assign issue_done_o = (~awvalid_o | awready_i) & (~wvalid_o | wready_i);
  assign b_hs_o       = resp_en_i & bvalid_i;
  assign b_err_o      = b_hs_o & (bresp_i != RESP_OKAY);

  always_comb begin
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    if (start_i) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
    end else begin
      if (awvalid_o && awready_i) aw_pend_d = 1'b0;
      if (wvalid_o && wready_i)   w_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

endmodule

// File: rtl/seg7_axil_writer.sv
// AXI4-Lite master writing a 24-bit hex value as six digit registers at BASE_ADDR + 4*i.
// SEG7_WRITER_SKIP_UNCHANGED_EN: skip digits whose shadow copy already matches the new value.
module seg7_axil_writer
  import seg7_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_value,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           done,
  output logic                           err,
  output logic [ADDR_WIDTH-1:0]          AWADDR,
  output logic [2:0]                     AWPROT,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [31:0]                    WDATA,
  output logic [3:0]                     WSTRB,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY
);

  wr_state_e                       state_q, state_d;
  idx_t                            idx_q, idx_d;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] value_q, value_d;
  logic                            err_q, err_d;
  logic                            start, skip, last;
  logic                            issue_done, b_hs, b_err;
  digit_t                          cur_digit;

  assign cur_digit = value_q[int'(idx_q)*DIGIT_BITS +: DIGIT_BITS];
  assign last      = (idx_q == idx_t'(NUM_DIGITS - 1));

`ifdef SEG7_WRITER_SKIP_UNCHANGED_EN
  digit_t                shadow_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_vld_q;

  assign skip = (state_q == ST_ISSUE) && shadow_vld_q[idx_q] && (shadow_q[idx_q] == cur_digit);

  // Only an OKAY response proves the peripheral now holds this digit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      shadow_vld_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= '0;
    end else if (b_hs && !b_err) begin
      shadow_vld_q[idx_q] <= 1'b1;
      shadow_q[idx_q]     <= cur_digit;
    end
  end
`else
  assign skip = 1'b0;
`endif

  seg7_axil_wr_beat u_beat (
    .clk_i        (ACLK),
    .rst_ni       (ARESETn),
    .start_i      (start),
    .issue_en_i   ((state_q == ST_ISSUE) && !skip),
    .resp_en_i    (state_q == ST_RESP),
    .awready_i    (AWREADY),
    .wready_i     (WREADY),
    .bvalid_i     (BVALID),
    .bresp_i      (BRESP),
    .awvalid_o    (AWVALID),
    .wvalid_o     (WVALID),
    .bready_o     (BREADY),
    .issue_done_o (issue_done),
    .b_hs_o       (b_hs),
    .b_err_o      (b_err)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    err_d   = err_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          value_d = in_value;
          err_d   = 1'b0;
          idx_d   = '0;
          start   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (skip) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + idx_t'(1);
            start = 1'b1;
          end
        end else if (issue_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          if (b_err) err_d = 1'b1;
          if (last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + idx_t'(1);
            start   = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign AWADDR   = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(DIGIT_STRIDE);
  assign AWPROT   = 3'b000;
  assign WDATA    = {{(32-DIGIT_BITS){1'b0}}, cur_digit};
  assign WSTRB    = 4'hF;

endmodule

// File: doc/seg7_axil_writer.md
# seg7_axil_writer

AXI4-Lite write master that drives the six-digit 7-segment register peripheral. It accepts a 24-bit hex value over a valid/ready port and issues one AXI4-Lite write per digit: six 32-bit registers at BASE_ADDR + 4·i, digit i = value[4i+3:4i]. It sits directly upstream of the 7-segment peripheral and lets fabric logic such as counters or debug probes update the display without the HPS.

## Interface
- ADDR_WIDTH, 32, AXI address width
- BASE_ADDR, 32'h0, byte address of digit 0 register
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- in_value  in  24  six hex digits, digit 0 in [3:0]
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- done  out  1  one-cycle pulse, sequence finished
- err  out  1  sticky: some BRESP != 2'b00 in last sequence; valid from done until next accept
- AWADDR  out  ADDR_WIDTH  write address
- AWPROT  out  3  constant 3'b000
- AWVALID / AWREADY  out / in  1  address handshake
- WDATA  out  32  {28'b0, digit}
- WSTRB  out  4  constant 4'hF
- WVALID / WREADY  out / in  1  data handshake
- BRESP  in  2  write response
- BVALID / BREADY  in / out  1  response handshake

## Operation
- States: IDLE, ISSUE, RESP, DONE. Digit counter idx 0..5. Pending flags aw_pend, w_pend.
- IDLE: in_ready=1. On accept: latch in_value, clear err, idx=0, go ISSUE.
- ISSUE: AWVALID=aw_pend, WVALID=w_pend; both set on entry. Each flag clears on its own handshake; AW and W may complete in the same or different cycles, in either order. Both clear -> RESP.
- RESP: BREADY=1. On BVALID: if BRESP != 2'b00 set err. If idx==5 -> DONE, else idx+1 -> ISSUE.
- Error never aborts the sequence; all six digits are always attempted.
- DONE: done=1 for one cycle -> IDLE.
- AWADDR = BASE_ADDR + {idx, 2'b00}, held stable while AWVALID. WDATA is held stable while WVALID. Neither may change before its handshake.
- in_value changes while busy are ignored; the latched copy is used.

## Timing
- Reset values: in_ready=1, done=0, err=0, AWVALID=0, WVALID=0, BREADY=0, AWADDR=BASE_ADDR, WDATA=0, idx=0.
- Accept at cycle T -> AWVALID/WVALID first high at T+1.
- Zero-wait slave: 2 cycles per digit (ISSUE, RESP). Against the 7-segment peripheral: 4 cycles per digit; last B handshake at T+24; done at T+25; in_ready high again at T+26.
- B handshake at cycle N -> next AWVALID at N+1.
- ARESETn low mid-sequence: all VALID and BREADY outputs drop immediately and asynchronously. State returns to IDLE and the partially written display is left as is. No done pulse.
- BVALID arriving while in ISSUE (protocol violation) is ignored until RESP.

## Configuration
- SEG7_WRITER_SKIP_UNCHANGED_EN defined:
  - Keep a shadow copy of each digit plus a per-digit valid bit, updated only on an OKAY response.
  - Digits whose shadow is valid and equal to the new value are skipped: idx advances with no bus traffic, at one cycle per skipped digit.
  - If all six digits are skipped, done pulses 7 cycles after accept with err=0.
  - Reset clears all valid bits, so the first sequence after reset always writes all six digits.
- Undefined: every accepted value writes all six digits; no shadow storage.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS=6, DIGIT_STRIDE=4, RESP_OKAY=2'b00
  - the state enum typedef
  - typedef digit_t = logic [3:0]
- The 7-segment peripheral is to import the same constants.
- Sub-module seg7_axil_wr_beat: single AW/W/B transaction engine (pending flags, BREADY, response capture). The top level sequences idx and the optional shadow logic.

## Test plan
- Reset, then in_value=24'h123456 against a zero-wait slave model -> writes in order (0x00,6), (0x04,5), (0x08,4), (0x0C,3), (0x10,2), (0x14,1); done at T+13; err=0.
- Slave delays AWREADY 3 cycles after WREADY on digit 2 -> AWADDR/WDATA stable throughout; exactly one AW and one W handshake per digit; sequence completes.
- Slave returns BRESP=2'b11 on digit 4 only -> digit 5 is still written; done with err=1; next accept clears err.
- Assert ARESETn low for 1 cycle during digit 3 RESP -> AWVALID/WVALID/BREADY=0 asynchronously; in_ready=1 after release; no done pulse.
- With SEG7_WRITER_SKIP_UNCHANGED_EN: write 24'hABCDEF, then 24'hABCDE0 -> second sequence makes a single write (0x00, 0); writing 24'hABCDE0 again -> no bus traffic, done 7 cycles after accept.
- Back-to-back in_valid held high -> second request accepted the cycle in_ready rises after done; no overlap of sequences.
